// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential imem requests,
// queues returned words in order and flushes in-flight fetches on redirect.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              DEPTH        = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]  r_fetch_pc;
    logic             r_started;
    logic [XLEN-1:0]  r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [AW-1:0]    r_alloc_ptr;
    logic [AW-1:0]    r_fill_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_occ;
    logic [CW-1:0]    r_pend;
    logic [CW-1:0]    r_drop;

    logic [CW:0]      w_budget;
    logic             w_drop_nz;
    logic             w_rsp_drop;
    logic             w_rsp_fill;
    logic             w_req_fire;
    logic             w_out_fire;
    logic [CW-1:0]    w_flush_drop;
    logic             w_unused_bits;

    assign w_budget       = {1'b0, r_occ} + {1'b0, r_drop};
    assign w_drop_nz      = (r_drop != '0);
    assign w_rsp_drop     = imem_rsp_valid & w_drop_nz;
    assign w_rsp_fill     = imem_rsp_valid & ~w_drop_nz;

    assign imem_req_valid = r_started & (w_budget < DEPTH_C);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign out_valid      = (r_occ != '0) & r_filled[r_rd_ptr];
    assign out_pc         = r_pc[r_rd_ptr];
    assign out_instr      = r_instr[r_rd_ptr];
    assign w_out_fire     = out_valid & out_ready;

    // Everything still owed by memory after this edge must be discarded.
    assign w_flush_drop   = r_drop + r_pend + CW'(w_req_fire)
                          - CW'(imem_rsp_valid);

    assign w_unused_bits  = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc  <= RESET_VECTOR;
            r_started   <= 1'b0;
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_pend      <= '0;
            r_drop      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else begin
            r_started <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
                r_filled    <= '0;
                r_alloc_ptr <= '0;
                r_fill_ptr  <= '0;
                r_rd_ptr    <= '0;
                r_occ       <= '0;
                r_pend      <= '0;
                r_drop      <= w_flush_drop;
            end else begin
                if (w_req_fire) begin
                    r_pc[r_alloc_ptr]     <= r_fetch_pc;
                    r_filled[r_alloc_ptr] <= 1'b0;
                    r_alloc_ptr           <= r_alloc_ptr + AW'(1);
                    r_fetch_pc            <= r_fetch_pc + XLEN'(4);
                end
                if (w_rsp_fill) begin
                    r_instr[r_fill_ptr]  <= imem_rsp_data;
                    r_filled[r_fill_ptr] <= 1'b1;
                    r_fill_ptr           <= r_fill_ptr + AW'(1);
                end
                if (w_out_fire) begin
                    r_filled[r_rd_ptr] <= 1'b0;
                    r_rd_ptr           <= r_rd_ptr + AW'(1);
                end
                r_occ  <= r_occ + CW'(w_req_fire) - CW'(w_out_fire);
                r_pend <= r_pend + CW'(w_req_fire) - CW'(w_rsp_fill);
                r_drop <= r_drop - CW'(w_rsp_drop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency memory model.
// Memory word at address A is ~A.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int n_cmp = 0;
    int n_mis = 0;
    int edge_n = 0;
    int lat = 1;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] req_log [$];
    logic [31:0] opc_log [$];
    logic [31:0] oin_log [$];
    logic [31:0] oed_log [$];

    fetch_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .DEPTH(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q [$],
                                         input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic clear_logs();
        req_log.delete();
        opc_log.delete();
        oin_log.delete();
        oed_log.delete();
    endtask

    task automatic mem_flush();
        mq_addr.delete();
        mq_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    endtask

    // One clock: observe handshakes mid-cycle, then update memory after edge.
    task automatic cycle();
        logic        fire;
        logic [31:0] faddr;
        @(negedge clk);
        fire  = reset && imem_req_valid && imem_req_ready;
        faddr = imem_req_addr;
        if (fire) req_log.push_back(faddr);
        if (reset && out_valid && out_ready) begin
            opc_log.push_back(out_pc);
            oin_log.push_back(out_instr);
            oed_log.push_back(32'(edge_n + 1));
        end
        @(posedge clk);
        edge_n++;
        #1;
        if (!reset) begin
            mem_flush();
            return;
        end
        if (fire) begin
            mq_addr.push_back(faddr);
            mq_due.push_back(edge_n + lat - 1);
        end
        if (mq_addr.size() > 0 && mq_due[0] <= edge_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq_addr[0];
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        mem_flush();
        repeat (2) cycle();
        reset = 1'b1;
        clear_logs();
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        lat            = 1;

        // Reset state and first-edge behaviour
        #12;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_logs();
        chk("first_edge_req_valid", 32'(imem_req_valid), 32'd0);
        cycle();
        chk("start_req_valid", 32'(imem_req_valid), 32'd1);
        chk("start_req_addr", imem_req_addr, 32'h0);

        // Streaming, latency 1
        repeat (8) cycle();
        chk("s_req0", qget(req_log, 0), 32'h0);
        chk("s_req1", qget(req_log, 1), 32'h4);
        chk("s_req3", qget(req_log, 3), 32'hC);
        chk("s_pc0", qget(opc_log, 0), 32'h0);
        chk("s_pc1", qget(opc_log, 1), 32'h4);
        chk("s_pc2", qget(opc_log, 2), 32'h8);
        chk("s_ins1", qget(oin_log, 1), 32'hFFFF_FFFB);
        chk("s_back2back", qget(oed_log, 3) - qget(oed_log, 0), 32'd3);

        // Mid-stream asynchronous reset
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_req_valid", 32'(imem_req_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        mem_flush();
        repeat (2) cycle();
        out_ready = 1'b0;
        reset = 1'b1;
        clear_logs();

        // Back-pressure from decode fills the queue
        repeat (10) cycle();
        chk("bp_restart_addr", qget(req_log, 0), 32'h0);
        chk("bp_req_count", 32'(req_log.size()), 32'd4);
        chk("bp_req3", qget(req_log, 3), 32'hC);
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_pc", out_pc, 32'h0);
        chk("bp_out_instr", out_instr, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("bp_drain0", qget(opc_log, 0), 32'h0);
        chk("bp_drain1", qget(opc_log, 1), 32'h4);
        chk("bp_drain2", qget(opc_log, 2), 32'h8);
        chk("bp_drain3", qget(opc_log, 3), 32'hC);
        chk("bp_resume", qget(req_log, 4), 32'h10);

        // Memory stalls the request at 0x8
        do_reset();
        repeat (3) cycle();
        chk("stall_addr_pre", imem_req_addr, 32'h8);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_addr", imem_req_addr, 32'h8);
            chk("stall_valid", 32'(imem_req_valid), 32'd1);
        end
        imem_req_ready = 1'b1;
        cycle();
        chk("stall_count", 32'(req_log.size()), 32'd3);
        chk("stall_after", imem_req_addr, 32'hC);

        // Latency 3, redirect with two outstanding plus one firing
        lat = 3;
        do_reset();
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        chk("rd_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd_req_addr", imem_req_addr, 32'h100);
        chk("rd_out_valid", 32'(out_valid), 32'd0);
        repeat (8) cycle();
        chk("rd_req3", qget(req_log, 3), 32'h100);
        chk("rd_pc0", qget(opc_log, 0), 32'h100);
        chk("rd_ins0", qget(oin_log, 0), 32'hFFFF_FEFF);
        chk("rd_pc1", qget(opc_log, 1), 32'h104);
        chk("rd_ins1", qget(oin_log, 1), 32'hFFFF_FEFB);

        // Redirect coinciding with output fire and response arrival
        lat = 1;
        do_reset();
        repeat (4) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
        chk("co_out_valid", 32'(out_valid), 32'd0);
        chk("co_req_addr", imem_req_addr, 32'h200);
        repeat (6) cycle();
        chk("co_pc0", qget(opc_log, 0), 32'h0);
        chk("co_pc1", qget(opc_log, 1), 32'h4);
        chk("co_pc2", qget(opc_log, 2), 32'h200);
        chk("co_ins2", qget(oin_log, 2), 32'hFFFF_FDFF);
        chk("co_pc3", qget(opc_log, 3), 32'h204);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RV32 cores. It owns the program counter and issues sequential requests to a latency-tolerant instruction memory over a valid/ready handshake. It buffers returned instructions with their PCs in a DEPTH-entry in-order queue, and discards in-flight fetches when execute redirects the PC (branch/jump). It replaces the single-cycle PC register + PC+4 adder + combinational instruction ROM path, and feeds decode through a valid/ready handshake.

## Interface
- XLEN, 32, address/PC width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, queue entries and maximum in-flight requests; power of 2, ≥2
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address, always 4-byte aligned
- imem_rsp_valid  in  1  response valid; exactly one per accepted request, in order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  head instruction valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  32  head instruction word

## Operation
- State: fetch_pc, started flag, queue (pc, instr, filled bit per entry), alloc/fill/read pointers, occupancy count occ (allocated entries), drop_cnt.
- Request fire = imem_req_valid & imem_req_ready. imem_req_valid = started & (occ + drop_cnt < DEPTH). imem_req_addr = fetch_pc.
- On request fire (no redirect): allocate entry at alloc pointer with pc = fetch_pc, filled = 0. Increment alloc pointer and occ; fetch_pc += 4 (mod 2^XLEN, wraps).
- On rsp_valid with drop_cnt > 0: decrement drop_cnt; data ignored. Otherwise write imem_rsp_data into the entry at the fill pointer, set filled, and advance the fill pointer.
- out_valid = filled bit of entry at read pointer with occ > 0. Output fire = out_valid & out_ready: clear entry, advance read pointer, decrement occ.
- Redirect cycle: fetch_pc ← {redirect_pc[XLEN-1:2],2'b00}. Queue emptied; all pointers equal, occ = 0, all filled bits cleared.
  - drop_cnt ← every request still outstanding at end of cycle: old drop_cnt + unfilled allocated entries + (1 if request fired this cycle) − (1 if response arrived this cycle).
  - An output fire in the redirect cycle counts as delivered.
- Invariant occ + drop_cnt ≤ DEPTH; pointers and counters sized accordingly ($clog2(DEPTH)+1 for counts).
- Reset asserted (any time, asynchronously): fetch_pc = RESET_VECTOR, started = 0, occ = 0, drop_cnt = 0, all filled bits 0, pointers 0. Memory-side responses to pre-reset requests are the memory's responsibility (memory is reset by the same signal).

## Timing
- During reset and the first rising edge after deassertion: imem_req_valid = 0, out_valid = 0. started sets on that first edge; the first request is presented in the following cycle with addr = RESET_VECTOR.
- imem_req_addr holds stable while imem_req_valid & !imem_req_ready, unless redirected.
- Response captured on the edge where imem_rsp_valid = 1; out_valid for it is visible the next cycle at the earliest (registered, no combinational rsp→out path).
- Sustained throughput is 1 instruction/cycle when memory latency L satisfies DEPTH ≥ L+1 and out_ready = 1.
- Redirect takes effect on the next edge. The first request to redirect_pc is presented the cycle after redirect only if drop_cnt < DEPTH; otherwise it waits for drops to drain.
- out_* outputs are stable while out_valid & !out_ready.

## Test plan
- Reset then release, imem ready=1, latency 1, out_ready=1 -> req addrs 0x0,0x4,0x8,…; out_pc 0x0,0x4,0x8 on consecutive cycles; out_instr matches memory contents.
- out_ready=0, DEPTH=4 -> exactly 4 requests (0x0–0xC) issued, then imem_req_valid=0; out_ready=1 -> drains in order, requests resume at 0x10.
- imem_req_ready=0 for 3 cycles with valid high at 0x8 -> addr held at 0x8; no fetch_pc advance.
- Latency 3, redirect to 0x103 with 2 requests outstanding plus 1 firing -> drop_cnt=3; 3 responses discarded; next out_pc=0x100 with its instruction.
- Redirect in the same cycle as an output fire and a response arrival -> fired instruction delivered once, response dropped, queue empty next cycle.
- Reset pulsed low mid-stream -> out_valid and imem_req_valid drop immediately; after release, fetch restarts at RESET_VECTOR.
